// File: rtl/gray_rd_arbiter.sv
// Two-requester round-robin arbiter for the gray-image memory read port.
// Supports bounded lock bursts and routes each returned byte back to the
// requester that issued it through an in-flight tag pipeline.
module gray_rd_arbiter #(
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_LOCK = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  localparam logic [3:0] MaxLock = 4'(MAX_LOCK);

  typedef enum logic [1:0] {StFree, StOwn0, StOwn1} own_e;

  own_e        state_q, state_d;
  logic        last_gnt_q, last_gnt_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;

  // Tag pipeline: stage 0 lines up with mem_rd, stage RD_LAT with valid mem_data.
  logic [RD_LAT:0] tag_v_q, tag_id_q;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              any_gnt;
  logic              gnt_id;
  logic              gnt_lock;
  logic [ADDR_W-1:0] gnt_addr;
  logic              own_req;
  logic              own_lock;
  logic [3:0]        lock_cnt_inc;

  assign any_gnt      = gnt0 | gnt1;
  assign gnt_id       = gnt1;
  assign gnt_lock     = gnt1 ? lock1 : lock0;
  assign gnt_addr     = gnt1 ? addr1 : addr0;
  assign own_req      = (state_q == StOwn1) ? req1 : req0;
  assign own_lock     = (state_q == StOwn1) ? lock1 : lock0;
  assign lock_cnt_inc = lock_cnt_q + 4'd1;

  // Owner state, round-robin history and lock counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFree;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Next owner state: enter OWNx on a locked grant, leave on unlock or when the burst cap is hit.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_gnt_d = any_gnt ? gnt_id : last_gnt_q;
    unique case (state_q)
      StFree: begin
        if (any_gnt) begin
          lock_cnt_d = 4'd1;
          if (gnt_lock && (MaxLock > 4'd1)) state_d = gnt_id ? StOwn1 : StOwn0;
        end
      end
      StOwn0, StOwn1: begin
        if (own_req) begin
          lock_cnt_d = lock_cnt_inc;
          // Reaching the cap forces release; last_gnt then favours the other side.
          if (!own_lock || (lock_cnt_inc >= MaxLock)) state_d = StFree;
        end else if (!own_lock) begin
          state_d = StFree;
        end
      end
      default: state_d = StFree;
    endcase
  end

  // Grant decode: round-robin when free, owner-only while locked.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      StFree: begin
        if (req0 && req1) begin
          gnt0 = last_gnt_q;
          gnt1 = !last_gnt_q;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
      StOwn0:  gnt0 = req0;
      StOwn1:  gnt1 = req1;
      default: ;
    endcase
  end

  // Issue the granted read and advance the in-flight tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      mem_addr_q <= '0;
    end else begin
      tag_v_q  <= {tag_v_q[RD_LAT-1:0], any_gnt};
      tag_id_q <= {tag_id_q[RD_LAT-1:0], gnt_id};
      if (any_gnt) mem_addr_q <= gnt_addr;
    end
  end

  // Capture returning data for the tagged requester; the other side holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= tag_v_q[RD_LAT] & !tag_id_q[RD_LAT];
      rvalid1_q <= tag_v_q[RD_LAT] & tag_id_q[RD_LAT];
      if (tag_v_q[RD_LAT] && !tag_id_q[RD_LAT]) rdata0_q <= mem_data;
      if (tag_v_q[RD_LAT] && tag_id_q[RD_LAT])  rdata1_q <= mem_data;
    end
  end

  assign mem_rd   = tag_v_q[0];
  assign mem_addr = mem_addr_q;
  assign busy     = |tag_v_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule
